// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes and
// the FSM state encoding.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_SW  = 32'h8000_0003;
  localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MTVAL,
    ST_W_MSTATUS,
    ST_JUMP,
    ST_R_MSTATUS,
    ST_MJUMP
  } state_e;

  // States that drive a CSR write and therefore yield to an idex write.
  function automatic logic is_write_state(input state_e s);
    return (s == ST_W_MEPC) || (s == ST_W_MCAUSE) || (s == ST_W_MTVAL) ||
           (s == ST_W_MSTATUS) || (s == ST_R_MSTATUS);
  endfunction

endpackage

// File: rtl/trap_prio.sv
// Combinational event selector: picks the highest-priority exception, mret or
// enabled interrupt and produces its cause, return PC and trap value.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic        exc_ecall_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_illegal_i,
  input  logic        mret_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_pc_i,
  input  logic [31:0] next_pc_i,
  input  logic        int_ok_i,
  input  logic        ex_trap_i,
  input  logic        soft_trap_i,
  input  logic        tcmp_trap_i,
  input  logic        mie_i,
  output logic        valid_o,
  output logic        is_mret_o,
  output logic [31:0] cause_o,
  output logic [31:0] ret_pc_o,
  output logic [31:0] tval_o
);

  logic irq_en;
  assign irq_en = mie_i & int_ok_i;

  // NOTE: every output gets a default before the priority chain so no path
  // through always_comb leaves a variable unassigned, which would infer a latch.
  always_comb begin
    valid_o   = 1'b0;
    is_mret_o = 1'b0;
    cause_o   = '0;
    ret_pc_o  = '0;
    tval_o    = '0;
    if (exc_illegal_i) begin
      valid_o  = 1'b1;
      cause_o  = CAUSE_ILLEGAL;
      ret_pc_o = inst_pc_i;
      tval_o   = inst_i;
    end else if (exc_ebreak_i) begin
      valid_o  = 1'b1;
      cause_o  = CAUSE_EBREAK;
      ret_pc_o = inst_pc_i;
    end else if (exc_ecall_i) begin
      valid_o  = 1'b1;
      cause_o  = CAUSE_ECALL;
      ret_pc_o = inst_pc_i;
    end else if (mret_i) begin
      valid_o   = 1'b1;
      is_mret_o = 1'b1;
    end else if (irq_en && (ex_trap_i || soft_trap_i || tcmp_trap_i)) begin
      valid_o  = 1'b1;
      ret_pc_o = next_pc_i;
      if (ex_trap_i)        cause_o = CAUSE_IRQ_EXT;
      else if (soft_trap_i) cause_o = CAUSE_IRQ_SW;
      else                  cause_o = CAUSE_IRQ_TMR;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: on an exception, interrupt or mret it stalls the pipeline,
// walks the CSR trap channel in a fixed order and issues one redirect strobe.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit VECTORED      = 1'b1,
  parameter int RST_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_ecall_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_illegal_i,
  input  logic        mret_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_pc_i,
  input  logic [31:0] next_pc_i,
  input  logic        int_ok_i,
  input  logic        ex_trap_i,
  input  logic        soft_trap_i,
  input  logic        tcmp_trap_i,
  input  logic        mstatus_MIE3,
  input  logic [31:0] mepc_i,
  input  logic        idex_csr_we_i,
  output logic        trap_csr_we_o,
  output logic [11:0] trap_csr_addr_o,
  output logic [31:0] trap_csr_wdata_o,
  input  logic [31:0] trap_csr_rdata_i,
  output logic        hold_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o
);

  if (RST_PC_UNUSED != 0) begin : g_rst_pc_check
    $error("trap_ctrl: RST_PC_UNUSED is reserved and must be 0");
  end

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;

  logic        ev_valid, ev_is_mret;
  logic [31:0] ev_cause, ev_ret_pc, ev_tval;

  trap_prio u_prio (
    .exc_ecall_i   (exc_ecall_i),
    .exc_ebreak_i  (exc_ebreak_i),
    .exc_illegal_i (exc_illegal_i),
    .mret_i        (mret_i),
    .inst_i        (inst_i),
    .inst_pc_i     (inst_pc_i),
    .next_pc_i     (next_pc_i),
    .int_ok_i      (int_ok_i),
    .ex_trap_i     (ex_trap_i),
    .soft_trap_i   (soft_trap_i),
    .tcmp_trap_i   (tcmp_trap_i),
    .mie_i         (mstatus_MIE3),
    .valid_o       (ev_valid),
    .is_mret_o     (ev_is_mret),
    .cause_o       (ev_cause),
    .ret_pc_o      (ev_ret_pc),
    .tval_o        (ev_tval)
  );

  // Vectored mode applies only to interrupts; the code is the cause without bit 31.
  logic [31:0] mtvec_base, vec_off, trap_target;
  assign mtvec_base  = {trap_csr_rdata_i[31:2], 2'b00};
  assign vec_off     = (cause_q & 32'h7FFF_FFFF) << 2;
  assign trap_target = (VECTORED && trap_csr_rdata_i[0] && cause_q[31])
                       ? mtvec_base + vec_off : mtvec_base;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    pc_d             = pc_q;
    tval_d           = tval_q;
    trap_csr_we_o    = 1'b0;
    trap_csr_addr_o  = '0;
    trap_csr_wdata_o = '0;
    hold_o           = 1'b0;
    jump_en_o        = 1'b0;
    jump_addr_o      = '0;

    unique case (state_q)
      ST_IDLE: begin
        hold_o = ev_valid;
        if (ev_valid) begin
          if (ev_is_mret) begin
            state_d = ST_R_MSTATUS;
          end else begin
            state_d = ST_W_MEPC;
            cause_d = ev_cause;
            pc_d    = ev_ret_pc;
            tval_d  = ev_tval;
          end
        end
      end
      ST_W_MEPC: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MEPC;
        trap_csr_wdata_o = pc_q;
        state_d          = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MCAUSE;
        trap_csr_wdata_o = cause_q;
        state_d          = ST_W_MTVAL;
      end
      ST_W_MTVAL: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MTVAL;
        trap_csr_wdata_o = tval_q;
        state_d          = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr_wdata_o = {24'h0, trap_csr_rdata_i[3], 7'h0};
        state_d          = ST_JUMP;
      end
      ST_JUMP: begin
        hold_o          = 1'b1;
        trap_csr_addr_o = CSR_MTVEC;
        jump_en_o       = 1'b1;
        jump_addr_o     = trap_target;
        state_d         = ST_IDLE;
      end
      ST_R_MSTATUS: begin
        hold_o           = 1'b1;
        trap_csr_we_o    = 1'b1;
        trap_csr_addr_o  = CSR_MSTATUS;
        trap_csr_wdata_o = {24'h0, 1'b1, 3'h0, trap_csr_rdata_i[7], 3'h0};
        state_d          = ST_MJUMP;
      end
      ST_MJUMP: begin
        hold_o      = 1'b1;
        jump_en_o   = 1'b1;
        jump_addr_o = mepc_i;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An idex CSR write wins the port; stay put and retry the same write.
    if (is_write_state(state_q) && idex_csr_we_i) state_d = state_q;
  end

endmodule
